// File: rtl/mem_access_initiator.sv
// Load/store initiator for the single-cycle-strobe SRAM controller interface.
// One access outstanding at a time, with lane swapping, ack timeout and read-data extension.
module mem_access_initiator #(
  parameter int ADDR_BITS      = 16,
  parameter int XLEN           = 32,
  parameter int EXT_BITS       = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [ADDR_BITS:0]       req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [XLEN-1:0]          req_wdata_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_error_o,
  output logic [XLEN-1:0]          rsp_rdata_o,
  output logic [ADDR_BITS-1:0]     mem_addr_o,
  output logic                     mem_read_en_o,
  output logic [3:0]               mem_write_en_o,
  output logic [EXT_BITS+XLEN-1:0] mem_write_data_o,
  input  logic [EXT_BITS+XLEN-1:0] mem_read_data_i,
  input  logic                     mem_read_ack_i,
  input  logic                     mem_write_ack_i,
  input  logic [ADDR_BITS-1:0]     mem_addr_ack_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_READ_WAIT  = 3'd2,
    S_WRITE_WAIT = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic                       write_q, write_d;
  logic [1:0]                 size_q, size_d;
  logic                       unsigned_q, unsigned_d;
  logic                       lsb_q, lsb_d;
  logic [3:0]                 be_q, be_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       req_ready_q, req_ready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_error_q, rsp_error_d;
  logic [XLEN-1:0]            rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic                       mem_read_en_q, mem_read_en_d;
  logic [3:0]                 mem_write_en_q, mem_write_en_d;
  logic [EXT_BITS+XLEN-1:0]   mem_write_data_q, mem_write_data_d;

  logic accept_s, bad_s, timeout_s, unused_ext_s;

  assign accept_s     = (state_q == S_IDLE) && req_ready_q && req_valid_i;
  assign bad_s        = (req_size_i == 2'd3) || ((req_size_i != 2'd0) && req_addr_i[0]);
  assign timeout_s    = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign unused_ext_s = ^mem_read_data_i[EXT_BITS+XLEN-1:XLEN];

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic lsb, input logic odd);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lsb;
      2'd1:    be = 4'b0011;
      default: be = 4'b1111;
    endcase
    lane_be = odd ? {be[1:0], be[3:2]} : be;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] size, input logic [XLEN-1:0] w,
                                                input logic odd);
    logic [XLEN-1:0] d;
    case (size)
      2'd0:    d = {4{w[7:0]}};
      2'd1:    d = {2{w[15:0]}};
      default: d = w;
    endcase
    lane_data = odd ? {d[15:0], d[31:16]} : d;
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [1:0] size, input logic lsb,
                                              input logic uns, input logic [XLEN-1:0] d);
    logic [7:0] b;
    b = lsb ? d[15:8] : d[7:0];
    case (size)
      2'd0:    extract = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      2'd1:    extract = uns ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
      default: extract = d;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      write_q          <= 1'b0;
      size_q           <= 2'd0;
      unsigned_q       <= 1'b0;
      lsb_q            <= 1'b0;
      be_q             <= 4'd0;
      cnt_q            <= '0;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_error_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      mem_addr_q       <= '0;
      mem_read_en_q    <= 1'b0;
      mem_write_en_q   <= 4'd0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      unsigned_q       <= unsigned_d;
      lsb_q            <= lsb_d;
      be_q             <= be_d;
      cnt_q            <= cnt_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_error_q      <= rsp_error_d;
      rsp_rdata_q      <= rsp_rdata_d;
      mem_addr_q       <= mem_addr_d;
      mem_read_en_q    <= mem_read_en_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = bad_s ? S_RESP : S_ISSUE;
        else          state_d = S_IDLE;
      end
      S_ISSUE: state_d = write_q ? S_WRITE_WAIT : S_READ_WAIT;
      S_READ_WAIT: begin
        if (mem_read_ack_i || timeout_s) state_d = S_RESP;
        else                             state_d = S_READ_WAIT;
      end
      S_WRITE_WAIT: begin
        if (mem_write_ack_i || timeout_s) state_d = S_RESP;
        else                              state_d = S_WRITE_WAIT;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs (ack beats timeout)
  always_comb begin
    write_d          = write_q;
    size_d           = size_q;
    unsigned_d       = unsigned_q;
    lsb_d            = lsb_q;
    be_d             = be_q;
    cnt_d            = cnt_q;
    rsp_error_d      = 1'b0;
    rsp_rdata_d      = rsp_rdata_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          write_d          = req_write_i;
          size_d           = req_size_i;
          unsigned_d       = req_unsigned_i;
          lsb_d            = req_addr_i[0];
          be_d             = lane_be(req_size_i, req_addr_i[0], req_addr_i[1]);
          mem_addr_d       = req_addr_i[ADDR_BITS:1];
          mem_write_data_d = {{EXT_BITS{1'b0}}, lane_data(req_size_i, req_wdata_i, req_addr_i[1])};
          rsp_error_d      = bad_s;
        end else begin
          rsp_error_d = 1'b0;
        end
      end
      S_ISSUE: cnt_d = CW'(1);
      S_READ_WAIT: begin
        if (mem_read_ack_i) begin
          rsp_rdata_d = extract(size_q, lsb_q, unsigned_q, mem_read_data_i[XLEN-1:0]);
          rsp_error_d = (mem_addr_ack_i != mem_addr_q);
        end else if (timeout_s) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE_WAIT: begin
        if (mem_write_ack_i) begin
          rsp_error_d = 1'b0;
        end else if (timeout_s) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
    req_ready_d    = (state_d == S_IDLE);
    rsp_valid_d    = (state_d == S_RESP);
    mem_read_en_d  = (state_d == S_ISSUE) && !write_d;
    mem_write_en_d = ((state_d == S_ISSUE) && write_d) ? be_d : 4'd0;
  end

  assign req_ready_o      = req_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_error_o      = rsp_error_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_read_en_o    = mem_read_en_q;
  assign mem_write_en_o   = mem_write_en_q;
  assign mem_write_data_o = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator: hand-computed vectors, manual ack driving.
module tb_mem_access_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [16:0] req_addr = 17'd0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_error, mem_read_en;
  logic [31:0] rsp_rdata;
  logic [15:0] mem_addr, mem_addr_ack = 16'd0;
  logic [3:0]  mem_write_en;
  logic [32:0] mem_write_data, mem_read_data = 33'd0;
  logic        mem_read_ack = 1'b0, mem_write_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_access_initiator dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_error_o(rsp_error), .rsp_rdata_o(rsp_rdata),
    .mem_addr_o(mem_addr), .mem_read_en_o(mem_read_en), .mem_write_en_o(mem_write_en),
    .mem_write_data_o(mem_write_data), .mem_read_data_i(mem_read_data),
    .mem_read_ack_i(mem_read_ack), .mem_write_ack_i(mem_write_ack),
    .mem_addr_ack_i(mem_addr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one accept cycle; returns in cycle 1.
  task automatic start(input logic w, input logic [16:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd);
    req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic read_txn(input string tag, input logic [16:0] a, input logic [1:0] s,
                          input logic u, input logic [31:0] d, input logic [15:0] ack_a,
                          input logic [15:0] exp_a, input logic [31:0] exp_d, input logic exp_e);
    start(1'b0, a, s, u, 32'd0);
    chk({tag, " addr"}, mem_addr, exp_a);
    chk({tag, " rd_en c1"}, mem_read_en, 1'b1);
    chk({tag, " wr_en c1"}, mem_write_en, 4'd0);
    tick();
    chk({tag, " rd_en c2"}, mem_read_en, 1'b0);
    tick();
    mem_read_ack = 1'b1; mem_read_data = {1'b1, d}; mem_addr_ack = ack_a;
    chk({tag, " rsp_valid c3"}, rsp_valid, 1'b0);
    tick();
    mem_read_ack = 1'b0;
    chk({tag, " rsp_valid c4"}, rsp_valid, 1'b1);
    chk({tag, " rsp_error"}, rsp_error, exp_e);
    if (!exp_e) chk({tag, " rdata"}, rsp_rdata, exp_d);
    tick();
    chk({tag, " rsp_valid c5"}, rsp_valid, 1'b0);
    chk({tag, " ready c5"}, req_ready, 1'b1);
  endtask

  task automatic write_txn(input string tag, input logic [16:0] a, input logic [1:0] s,
                           input logic [31:0] wd, input logic [15:0] exp_a, input logic [3:0] exp_be,
                           input logic [32:0] exp_wd, input logic [31:0] held_rd);
    start(1'b1, a, s, 1'b0, wd);
    chk({tag, " addr"}, mem_addr, exp_a);
    chk({tag, " be"}, mem_write_en, exp_be);
    chk({tag, " wdata"}, mem_write_data, exp_wd);
    chk({tag, " rd_en"}, mem_read_en, 1'b0);
    tick();
    chk({tag, " be c2"}, mem_write_en, 4'd0);
    mem_write_ack = 1'b1;
    tick();
    mem_write_ack = 1'b0;
    chk({tag, " rsp_valid c3"}, rsp_valid, 1'b1);
    chk({tag, " rsp_error"}, rsp_error, 1'b0);
    chk({tag, " rdata held"}, rsp_rdata, held_rd);
    tick();
    chk({tag, " rsp_valid c4"}, rsp_valid, 1'b0);
  endtask

  task automatic bad_txn(input string tag, input logic w, input logic [16:0] a, input logic [1:0] s);
    start(w, a, s, 1'b0, 32'h0000_FFFF);
    chk({tag, " rsp_valid c1"}, rsp_valid, 1'b1);
    chk({tag, " rsp_error"}, rsp_error, 1'b1);
    chk({tag, " rd_en"}, mem_read_en, 1'b0);
    chk({tag, " wr_en"}, mem_write_en, 4'd0);
    tick();
    chk({tag, " rsp_valid c2"}, rsp_valid, 1'b0);
    chk({tag, " ready c2"}, req_ready, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    chk("reset ready", req_ready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset mem_addr", mem_addr, 16'd0);
    chk("reset wr_en", mem_write_en, 4'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready after reset", req_ready, 1'b1);

    read_txn("word rd", 17'h0006, 2'd2, 1'b0, 32'hA1B2C3D4, 16'h0003, 16'h0003, 32'hA1B2C3D4, 1'b0);
    write_txn("byte st", 17'h0003, 2'd0, 32'h0000_005A, 16'h0001, 4'b1000, 33'h0_5A5A_5A5A, 32'hA1B2C3D4);
    read_txn("sbyte rd", 17'h0005, 2'd0, 1'b0, 32'h0000_80FF, 16'h0002, 16'h0002, 32'hFFFF_FF80, 1'b0);
    read_txn("ubyte rd", 17'h0005, 2'd0, 1'b1, 32'h0000_80FF, 16'h0002, 16'h0002, 32'h0000_0080, 1'b0);
    read_txn("shalf rd", 17'h0002, 2'd1, 1'b0, 32'h0000_8001, 16'h0001, 16'h0001, 32'hFFFF_8001, 1'b0);
    write_txn("word st odd", 17'h0002, 2'd2, 32'h1122_3344, 16'h0001, 4'b1111, 33'h0_3344_1122, 32'hFFFF_8001);
    bad_txn("misaligned half st", 1'b1, 17'h0003, 2'd1);
    bad_txn("size3 ld", 1'b0, 17'h0000, 2'd3);

    start(1'b0, 17'h0010, 2'd2, 1'b0, 32'd0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk("timeout wait rsp_valid", rsp_valid, 1'b0);
    end
    tick();
    chk("timeout rsp_valid", rsp_valid, 1'b1);
    chk("timeout rsp_error", rsp_error, 1'b1);
    chk("timeout rdata", rsp_rdata, 32'd0);
    tick();
    tick();
    tick();
    mem_read_ack = 1'b1; mem_read_data = 33'h0_DEAD_BEEF; mem_addr_ack = 16'h0008;
    tick();
    mem_read_ack = 1'b0;
    chk("late ack dropped", rsp_valid, 1'b0);
    chk("late ack ready", req_ready, 1'b1);
    read_txn("after timeout", 17'h0010, 2'd2, 1'b0, 32'h1234_5678, 16'h0008, 16'h0008, 32'h1234_5678, 1'b0);

    start(1'b0, 17'h000A, 2'd2, 1'b0, 32'd0);
    chk("pre-reset rd_en", mem_read_en, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("midreset mem_addr", mem_addr, 16'd0);
    chk("midreset ready", req_ready, 1'b0);
    chk("midreset rsp_valid", rsp_valid, 1'b0);
    chk("midreset wdata", mem_write_data, 33'd0);
    chk("midreset rdata", rsp_rdata, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post-reset ready", req_ready, 1'b1);
    mem_read_ack = 1'b1; mem_read_data = 33'h0_0BAD_0BAD; mem_addr_ack = 16'h0005;
    tick();
    mem_read_ack = 1'b0;
    chk("post-reset ack dropped", rsp_valid, 1'b0);
    tick();
    chk("post-reset still idle", rsp_valid, 1'b0);

    read_txn("addr echo mismatch", 17'h0006, 2'd2, 1'b0, 32'hCAFE_F00D, 16'h0004, 16'h0003, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
